// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_pkg
// Purpose  : Shared constants and types for the ALU-sharing sequencer.
//            ALU op codes, default widths and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_share_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W_DEF  = 3;

  // ALU op codes understood by the external ALU (011/101 return zero)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl_if
// Purpose  : Request, ALU and response signals of the ALU-sharing sequencer.
//            slave  = sequencer side, master = requesters/ALU/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
);
  // Requester channel; requester i sits at [i*WIDTH +: WIDTH] / [i*OP_W +: OP_W]
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_num1;
  logic [2*WIDTH-1:0] req_num2;
  logic [2*OP_W-1:0]  req_op;
  // Shared combinational ALU
  logic [WIDTH-1:0]   alu_num1;
  logic [WIDTH-1:0]   alu_num2;
  logic [OP_W-1:0]    alu_op;
  logic [WIDTH-1:0]   alu_ans;
  logic               alu_zero;
  // Response channel
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_ans;
  logic               rsp_zero;

  modport slave (
    input  req_valid, req_num1, req_num2, req_op, alu_ans, alu_zero, rsp_ready,
    output req_ready, alu_num1, alu_num2, alu_op, rsp_valid, rsp_id, rsp_ans, rsp_zero
  );

  modport master (
    output req_valid, req_num1, req_num2, req_op, alu_ans, alu_zero, rsp_ready,
    input  req_ready, alu_num1, alu_num2, alu_op, rsp_valid, rsp_id, rsp_ans, rsp_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arb2
// Purpose  : Two-way grant logic. Round-robin by default; with
//            ALU_SHARE_PRIO_EN defined, fixed priority to requester 0 and no
//            pointer register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arb2 (
`ifndef ALU_SHARE_PRIO_EN
  input  wire logic       clk,
  input  wire logic       rst_n,
`endif
  input  wire logic       en_i,     // grants only allowed while sequencer idle
  input  wire logic [1:0] req_i,
  output logic      [1:0] grant_o
);

`ifdef ALU_SHARE_PRIO_EN
  // Requester 0 wins every contention
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      grant_o[0] = req_i[0];
      grant_o[1] = req_i[1] & ~req_i[0];
    end
  end
`else
  logic ptr_q;
  logic ptr_d;

  // Pointer names the preferred requester; a lone requester wins regardless
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    if (|grant_o) begin
      ptr_d = ~grant_o[1];
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Shares one external combinational ALU between two requesters.
//            IDLE grants one request, ISSUE drives the ALU from latched
//            operands for a full cycle, RESP holds the result until taken.
//            Build option ALU_SHARE_PRIO_EN selects fixed-priority grant.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  alu_share_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num1_q,  num1_d;
  logic [WIDTH-1:0] num2_q,  num2_d;
  logic [OP_W-1:0]  op_q,    op_d;
  logic             id_q,    id_d;
  logic [WIDTH-1:0] ans_q,   ans_d;
  logic             zero_q,  zero_d;
  logic [1:0]       grant;
  logic             grant_en;

  // rst_n gates the grant so req_ready reads 0 while reset is asserted
  assign grant_en = (state_q == S_IDLE) && rst_n;

  alu_rr_arb2 u_arb (
`ifndef ALU_SHARE_PRIO_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .en_i    (grant_en),
    .req_i   (bus.req_valid),
    .grant_o (grant)
  );

  // Next state, operand latch on grant, result capture at end of ISSUE
  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    op_d    = op_q;
    id_d    = id_q;
    ans_d   = ans_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          id_d    = grant[1];
          num1_d  = grant[1] ? bus.req_num1[WIDTH +: WIDTH] : bus.req_num1[0 +: WIDTH];
          num2_d  = grant[1] ? bus.req_num2[WIDTH +: WIDTH] : bus.req_num2[0 +: WIDTH];
          op_d    = grant[1] ? bus.req_op[OP_W +: OP_W]     : bus.req_op[0 +: OP_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ans_d   = bus.alu_ans;
        // The ALU zero flag is only meaningful for subtraction
        zero_d  = (op_q == OP_W'(ALU_SUB)) && bus.alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      ans_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      id_q    <= id_d;
      ans_q   <= ans_d;
      zero_q  <= zero_d;
    end
  end

  // ALU inputs come straight from the latches, so they only move on a grant
  assign bus.req_ready = grant;
  assign bus.alu_num1  = num1_q;
  assign bus.alu_num2  = num2_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_ans   = ans_q;
  assign bus.rsp_zero  = zero_q;

endmodule
`default_nettype wire
